// File: rtl/mmio_seg7_if.sv
// rtl/mmio_seg7_if.sv - MMIO bus bundle shared by the CPU and the seven-segment display block
interface mmio_seg7_if;
   logic        mmio_read;
   logic        mmio_write;
   logic [31:0] mmio_addr;
   logic [31:0] mmio_write_data;
   logic        mmio_work;
   logic        mmio_done;
   logic [31:0] mmio_read_data;

   modport master (
      output mmio_read, mmio_write, mmio_addr, mmio_write_data,
      input  mmio_work, mmio_done, mmio_read_data
   );

   modport slave (
      input  mmio_read, mmio_write, mmio_addr, mmio_write_data,
      output mmio_work, mmio_done, mmio_read_data
   );
endinterface

// File: rtl/mmio_seg7.sv
// rtl/mmio_seg7.sv - memory-mapped 8-digit common-anode seven-segment scanner
module mmio_seg7 #(
   parameter int SCAN_DIV = 100000
) (
   input  logic           sys_clk,
   input  logic           rst_n,
   mmio_seg7_if.slave     bus,
   output logic [7:0]     seg_pins,
   output logic [7:0]     digit_sel_pins
);
   localparam int PW = $clog2(SCAN_DIV);

   logic [PW-1:0] prescale;
   logic [2:0]    digit;

   logic [31:0] value_r;
   logic [7:0]  enable_r;
   logic [7:0]  dp_r;
   logic [7:0]  rawmode_r;
   logic [31:0] raw0_r;
   logic [31:0] raw1_r;

   logic [4:0]  reg_idx;
   logic [31:0] rd_mux;
   logic [3:0]  nibble;
   logic [7:0]  raw_byte;
   logic [7:0]  pattern;
   logic        unused_addr_lsb;

   assign bus.mmio_work = (bus.mmio_addr[31:16] == 16'hFFFF) &&
                          (bus.mmio_addr[15:7] == 9'b000000101);
   assign reg_idx         = bus.mmio_addr[6:2];
   assign unused_addr_lsb = &{1'b0, bus.mmio_addr[1:0]};

   function automatic logic [6:0] font7(input logic [3:0] n);
      case (n)
         4'h0: font7 = 7'h3F;
         4'h1: font7 = 7'h06;
         4'h2: font7 = 7'h5B;
         4'h3: font7 = 7'h4F;
         4'h4: font7 = 7'h66;
         4'h5: font7 = 7'h6D;
         4'h6: font7 = 7'h7D;
         4'h7: font7 = 7'h07;
         4'h8: font7 = 7'h7F;
         4'h9: font7 = 7'h6F;
         4'hA: font7 = 7'h77;
         4'hB: font7 = 7'h7C;
         4'hC: font7 = 7'h39;
         4'hD: font7 = 7'h5E;
         4'hE: font7 = 7'h79;
         default: font7 = 7'h71;
      endcase
   endfunction

   always_comb begin
      rd_mux = '0;
      case (reg_idx)
         5'd0: rd_mux = value_r;
         5'd1: rd_mux = {24'h0, enable_r};
         5'd2: rd_mux = {24'h0, dp_r};
         5'd3: rd_mux = {24'h0, rawmode_r};
         5'd4: rd_mux = raw0_r;
         5'd5: rd_mux = raw1_r;
         default: rd_mux = '0;
      endcase
   end

   // Part-select offsets are built by concatenation so the 3-bit index cannot overflow.
   always_comb begin
      nibble   = value_r[{digit, 2'b00} +: 4];
      raw_byte = digit[2] ? raw1_r[{digit[1:0], 3'b000} +: 8]
                          : raw0_r[{digit[1:0], 3'b000} +: 8];
      pattern  = 8'h00;
      if (enable_r[digit]) begin
         if (rawmode_r[digit])
            pattern = raw_byte;
         else
            pattern = {dp_r[digit], font7(nibble)};
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         prescale <= '0;
         digit    <= '0;
      end else if (prescale == PW'(SCAN_DIV - 1)) begin
         prescale <= '0;
         digit    <= digit + 3'd1;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         seg_pins       <= 8'hFF;
         digit_sel_pins <= 8'hFF;
      end else begin
         seg_pins       <= ~pattern;
         digit_sel_pins <= enable_r[digit] ? ~(8'b1 << digit) : 8'hFF;
      end
   end

   // A completed transaction always costs one idle cycle, so a held strobe yields done every other cycle.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         bus.mmio_done      <= 1'b0;
         bus.mmio_read_data <= '0;
         value_r            <= '0;
         enable_r           <= 8'hFF;
         dp_r               <= '0;
         rawmode_r          <= '0;
         raw0_r             <= '0;
         raw1_r             <= '0;
      end else if (bus.mmio_done) begin
         bus.mmio_done      <= 1'b0;
         bus.mmio_read_data <= '0;
      end else if (bus.mmio_write) begin
         bus.mmio_done      <= 1'b1;
         bus.mmio_read_data <= '0;
         if (bus.mmio_work) begin
            case (reg_idx)
               5'd0: value_r   <= bus.mmio_write_data;
               5'd1: enable_r  <= bus.mmio_write_data[7:0];
               5'd2: dp_r      <= bus.mmio_write_data[7:0];
               5'd3: rawmode_r <= bus.mmio_write_data[7:0];
               5'd4: raw0_r    <= bus.mmio_write_data;
               5'd5: raw1_r    <= bus.mmio_write_data;
               default: ;
            endcase
         end
      end else if (bus.mmio_read) begin
         bus.mmio_done      <= 1'b1;
         bus.mmio_read_data <= rd_mux;
      end else begin
         bus.mmio_done      <= 1'b0;
         bus.mmio_read_data <= '0;
      end
   end
endmodule

// File: tb/tb_mmio_seg7.sv
// tb/tb_mmio_seg7.sv - directed self-checking bench for mmio_seg7
module tb_mmio_seg7;
   logic       sys_clk;
   logic       rst_n;
   logic [7:0] seg_pins;
   logic [7:0] digit_sel_pins;

   int n_checks = 0;
   int n_fail   = 0;

   mmio_seg7_if bus ();

   mmio_seg7 #(.SCAN_DIV(4)) dut (
      .sys_clk        (sys_clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .seg_pins       (seg_pins),
      .digit_sel_pins (digit_sel_pins)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      bus.mmio_addr       = addr;
      bus.mmio_write_data = data;
      bus.mmio_write      = 1'b1;
      tick();
      check("wr_done", {31'h0, bus.mmio_done}, 32'd1);
      bus.mmio_write = 1'b0;
      tick();
      check("wr_done_clr", {31'h0, bus.mmio_done}, 32'd0);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      bus.mmio_addr = addr;
      bus.mmio_read = 1'b1;
      tick();
      check("rd_done", {31'h0, bus.mmio_done}, 32'd1);
      data = bus.mmio_read_data;
      bus.mmio_read = 1'b0;
      tick();
      check("rd_done_clr", {31'h0, bus.mmio_done}, 32'd0);
      check("rd_data_clr", bus.mmio_read_data, 32'd0);
   endtask

   // Advances until the select pins show the target, counting a timeout as a failure.
   task automatic wait_sel(input string tag, input logic [7:0] target);
      for (int k = 0; k < 200 && digit_sel_pins !== target; k++)
         tick();
      check(tag, {24'h0, digit_sel_pins}, {24'h0, target});
   endtask

   task automatic check_pins(input string tag, input logic [7:0] sel, input logic [7:0] seg);
      check({tag, "_sel"}, {24'h0, digit_sel_pins}, {24'h0, sel});
      check({tag, "_seg"}, {24'h0, seg_pins}, {24'h0, seg});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [5:0]  done_seq;

      rst_n               = 1'b0;
      bus.mmio_read       = 1'b0;
      bus.mmio_write      = 1'b0;
      bus.mmio_addr       = 32'h0;
      bus.mmio_write_data = 32'h0;
      repeat (3) tick();
      check_pins("reset", 8'hFF, 8'hFF);
      check("reset_done", {31'h0, bus.mmio_done}, 32'd0);
      check("reset_rdata", bus.mmio_read_data, 32'd0);
      rst_n = 1'b1;

      bus_read(32'hFFFF0284, rd);
      check("enable_default", rd, 32'h000000FF);

      bus.mmio_addr = 32'hFFFF0280;
      #1 check("work_lo", {31'h0, bus.mmio_work}, 32'd1);
      bus.mmio_addr = 32'hFFFF02FF;
      #1 check("work_hi", {31'h0, bus.mmio_work}, 32'd1);
      bus.mmio_addr = 32'hFFFF027C;
      #1 check("work_below", {31'h0, bus.mmio_work}, 32'd0);
      bus.mmio_addr = 32'hFFFF0300;
      #1 check("work_above", {31'h0, bus.mmio_work}, 32'd0);

      bus_write(32'hFFFF0280, 32'h0123ABCD);
      wait_sel("hex_d7_find", 8'h7F);
      check("hex_d7_seg", {24'h0, seg_pins}, 32'hC0);
      wait_sel("hex_wrap_find", 8'hFE);
      check("hex_d0_seg", {24'h0, seg_pins}, 32'hA1);
      repeat (4) tick();
      check_pins("hex_d1", 8'hFD, 8'hC6);
      repeat (4) tick();
      check_pins("hex_d2", 8'hFB, 8'h83);
      repeat (4) tick();
      check_pins("hex_d3", 8'hF7, 8'h88);
      repeat (4) tick();
      check_pins("hex_d4", 8'hEF, 8'hB0);

      bus_write(32'hFFFF0284, 32'hFFFFFF0F);
      bus_write(32'hFFFF0288, 32'h00000001);
      bus_write(32'hFFFF0280, 32'h00000008);
      bus_read(32'hFFFF0284, rd);
      check("enable_upper_zero", rd, 32'h0000000F);
      wait_sel("blank_d0_find", 8'hFE);
      check("blank_d0_seg", {24'h0, seg_pins}, 32'h00);
      wait_sel("blank_d1_find", 8'hFD);
      check("blank_d1_seg", {24'h0, seg_pins}, 32'hC0);
      wait_sel("blank_d3_find", 8'hF7);
      repeat (4) tick();
      check_pins("blank_slot4", 8'hFF, 8'hFF);
      repeat (8) tick();
      check_pins("blank_slot6", 8'hFF, 8'hFF);
      repeat (4) tick();
      check_pins("blank_slot7", 8'hFF, 8'hFF);

      bus_write(32'hFFFF028C, 32'h00000002);
      bus_write(32'hFFFF0290, 32'h00004900);
      wait_sel("raw_d1_find", 8'hFD);
      check("raw_d1_seg", {24'h0, seg_pins}, 32'hB6);
      bus_read(32'hFFFF0290, rd);
      check("raw0_read", rd, 32'h00004900);
      bus_read(32'hFFFF028C, rd);
      check("rawmode_read", rd, 32'h00000002);

      bus.mmio_addr       = 32'hFFFF0280;
      bus.mmio_write_data = 32'h12345678;
      bus.mmio_read       = 1'b1;
      bus.mmio_write      = 1'b1;
      tick();
      check("rw_done", {31'h0, bus.mmio_done}, 32'd1);
      check("rw_rdata", bus.mmio_read_data, 32'd0);
      bus.mmio_read  = 1'b0;
      bus.mmio_write = 1'b0;
      tick();
      bus_read(32'hFFFF0280, rd);
      check("rw_value", rd, 32'h12345678);

      bus_read(32'hFFFF029C, rd);
      check("word7_zero", rd, 32'h0);

      bus.mmio_addr = 32'hFFFF0284;
      bus.mmio_read = 1'b1;
      for (int k = 5; k >= 0; k--) begin
         tick();
         done_seq[k] = bus.mmio_done;
      end
      bus.mmio_read = 1'b0;
      tick();
      check("held_done_seq", {26'h0, done_seq}, {26'h0, 6'b101010});

      bus_write(32'hFFFF0300, 32'h0000DEAD);
      bus_read(32'hFFFF0280, rd);
      check("outside_no_write", rd, 32'h12345678);

      bus_write(32'hFFFF0284, 32'h000000FF);
      bus_write(32'hFFFF028C, 32'h00000000);
      wait_sel("mid_d5_find", 8'hDF);
      rst_n = 1'b0;
      tick();
      check_pins("mid_reset", 8'hFF, 8'hFF);
      check("mid_reset_done", {31'h0, bus.mmio_done}, 32'd0);
      rst_n = 1'b1;
      tick();
      check_pins("restart_d0", 8'hFE, 8'hC0);
      bus_read(32'hFFFF0280, rd);
      check("mid_reset_value", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
